rsa_vec_seq: RTL
================

RSA_VEC_SEQ -- requirements
Module: rsa_vec_seq

Interface
REQ-001 Parameter TIMEOUT, default 4096: max cycles waited for rsa_end per vector before declaring a fail.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; the only reset of this block.
REQ-004 run  input  1  single-cycle start request (already debounced/edge-detected upstream).
REQ-005 rsa_end  input  1  single-cycle completion pulse from the RSA core.
REQ-006 r  input  32  RSA core result; valid in the cycle rsa_end=1.
REQ-007 md_start  output  1  single-cycle start pulse to the RSA core.
REQ-008 base, exp, modulus  output  32 each  operands to the RSA core.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high after a sweep completes, until next run or reset.
REQ-011 pass_cnt, fail_cnt  output  3 each  vectors passed / failed in the current sweep.
REQ-012 first_fail  output  2  index of the first failing vector; first_fail_vld  output  1  qualifies it.
REQ-013 good, bad  output  1 each  sweep verdict LEDs.

Function
REQ-014 Internal fixed table, 4 vectors (base, exp, modulus, expected): V0=(52525252,17,128255609,8243011); V1=(2,10,1000,24); V2=(3,5,7,5); V3=(5,0,13,1).
REQ-015 FSM states: IDLE, LOAD, START, WAIT, CHECK, NEXT, DONE.
REQ-016 IDLE/DONE: run=1 -> LOAD; idx=0; pass_cnt, fail_cnt, first_fail, first_fail_vld, good, bad, done all cleared.
REQ-017 LOAD: base/exp/modulus driven from table[idx]; -> START next cycle.
REQ-018 START: md_start=1 for exactly this one cycle; timeout counter cleared; -> WAIT.
REQ-019 Latency: md_start high exactly 2 cycles after the cycle run is sampled high (and 2 cycles after each NEXT).
REQ-020 Operands stable from LOAD through end of CHECK for each vector; no change while the core runs.
REQ-021 WAIT: rsa_end=1 -> capture r, -> CHECK; else counter increments; counter reaching TIMEOUT with no rsa_end -> vector marked fail, -> NEXT.
REQ-022 rsa_end in the same cycle the counter reaches TIMEOUT: rsa_end wins, result checked normally.
REQ-023 CHECK: captured r == expected -> pass_cnt+1; else fail_cnt+1; -> NEXT.
REQ-024 On any fail (mismatch or timeout) with first_fail_vld=0: first_fail=idx, first_fail_vld=1; later fails leave them unchanged.
REQ-025 NEXT: idx=3 -> DONE; else idx+1 -> LOAD.
REQ-026 DONE entry: done=1, busy=0, good=(fail_cnt==0), bad=(fail_cnt!=0); held until run or rst.
REQ-027 busy=1 in LOAD..NEXT; run while busy is ignored.
REQ-028 rsa_end in IDLE, LOAD, START, CHECK, NEXT or DONE is ignored (no counter or state change).
REQ-029 pass_cnt+fail_cnt==4 in DONE; counters never wrap.

Reset
REQ-030 rst=1 (any state, including mid-WAIT): state=IDLE, idx=0, md_start=0, busy=0, done=0, good=0, bad=0, counters/first_fail/first_fail_vld=0, base/exp/modulus=0, timeout counter=0.
REQ-031 After rst deasserts, block stays in IDLE until run; a core completion arriving post-reset is ignored.

Verification
REQ-032 Behavioural core model (correct modexp, 40-cycle latency), run pulse -> four md_start pulses, operands per REQ-014; DONE with pass_cnt=4, fail_cnt=0, good=1, bad=0, first_fail_vld=0.
REQ-033 Model returns 24+1=25 for V1 only -> pass_cnt=3, fail_cnt=1, first_fail=1, first_fail_vld=1, good=0, bad=1.
REQ-034 TIMEOUT=64, model never responds to V2 -> V2 fails after 64 WAIT cycles, V3 still runs; fail_cnt=1, first_fail=2, bad=1.
REQ-035 rsa_end coincident with timeout expiry on V0 with r=8243011 -> V0 counted pass.
REQ-036 rst asserted mid-WAIT of V1 -> all outputs zero same cycle (async); subsequent rsa_end ignored; new run restarts from V0.
REQ-037 run pulses during busy and repeated run in DONE -> busy ones ignored; DONE run clears counters/verdict and restarts, md_start 2 cycles later.

Source files
------------

// File: rtl/rsa_vec_seq.sv
// Self-test sequencer for an RSA modexp core: sweeps a fixed 4-vector table,
// checks each result and reports pass/fail counts and a sweep verdict.
module rsa_vec_seq #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        rsa_end,
  input  logic [31:0] r,
  output logic        md_start,
  output logic [31:0] base,
  output logic [31:0] exp,
  output logic [31:0] modulus,
  output logic        busy,
  output logic        done,
  output logic [2:0]  pass_cnt,
  output logic [2:0]  fail_cnt,
  output logic [1:0]  first_fail,
  output logic        first_fail_vld,
  output logic        good,
  output logic        bad
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Packed tables: element [i] is vector Vi.
  localparam logic [3:0][31:0] T_BASE = {32'd5, 32'd3, 32'd2,    32'd52525252};
  localparam logic [3:0][31:0] T_EXP  = {32'd0, 32'd5, 32'd10,   32'd17};
  localparam logic [3:0][31:0] T_MOD  = {32'd13, 32'd7, 32'd1000, 32'd128255609};
  localparam logic [3:0][31:0] T_RES  = {32'd1, 32'd5, 32'd24,   32'd8243011};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [TW-1:0] r_tmo;
  logic [31:0] r_res;
  logic        r_md_start, r_busy, r_done, r_good, r_bad, r_ff_vld;
  logic [31:0] r_base, r_exp, r_mod;
  logic [2:0]  r_pass, r_fail;
  logic [1:0]  r_ff;
  logic [1:0]  w_idx_nxt;

  assign w_idx_nxt = r_idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_res      <= '0;
      r_md_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_good     <= 1'b0;
      r_bad      <= 1'b0;
      r_base     <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_ff       <= '0;
      r_ff_vld   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (run) begin
            r_idx    <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_ff     <= '0;
            r_ff_vld <= 1'b0;
            r_good   <= 1'b0;
            r_bad    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_base   <= T_BASE[0];
            r_exp    <= T_EXP[0];
            r_mod    <= T_MOD[0];
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_md_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_md_start <= 1'b0;
          r_tmo      <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the expiry cycle still counts as a response.
          if (rsa_end) begin
            r_res   <= r;
            r_state <= S_CHECK;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_tmo  <= r_tmo + 1'b1;
            r_fail <= r_fail + 3'd1;
            if (!r_ff_vld) begin
              r_ff     <= r_idx;
              r_ff_vld <= 1'b1;
            end
            r_state <= S_NEXT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CHECK: begin
          if (r_res == T_RES[r_idx]) begin
            r_pass <= r_pass + 3'd1;
          end else begin
            r_fail <= r_fail + 3'd1;
            if (!r_ff_vld) begin
              r_ff     <= r_idx;
              r_ff_vld <= 1'b1;
            end
          end
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_idx == 2'd3) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_good  <= (r_fail == 3'd0);
            r_bad   <= (r_fail != 3'd0);
            r_state <= S_DONE;
          end else begin
            r_idx   <= w_idx_nxt;
            r_base  <= T_BASE[w_idx_nxt];
            r_exp   <= T_EXP[w_idx_nxt];
            r_mod   <= T_MOD[w_idx_nxt];
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_start       = r_md_start;
  assign base           = r_base;
  assign exp            = r_exp;
  assign modulus        = r_mod;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign first_fail     = r_ff;
  assign first_fail_vld = r_ff_vld;
  assign good           = r_good;
  assign bad            = r_bad;

endmodule
